// File: rtl/acumulador_pkg.sv
// Shared definitions for the accumulator slice: ACC_MODE operation codes.
// Optional build macro ACC_TRISTATE_EN is consumed by acumulador_param.
package acumulador_pkg;

    typedef logic [2:0] acc_mode_t;

    localparam acc_mode_t MODE_HOLD = 3'b000;
    localparam acc_mode_t MODE_LOAD = 3'b001;
    localparam acc_mode_t MODE_SHL  = 3'b010;
    localparam acc_mode_t MODE_SHR  = 3'b011;
    localparam acc_mode_t MODE_ROL  = 3'b100;
    localparam acc_mode_t MODE_ROR  = 3'b101;
    localparam acc_mode_t MODE_INC  = 3'b110;
    localparam acc_mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/acumulador_nucleo.sv
// Accumulator datapath core: next accumulator value and next carry,
// purely combinational from the current state, the operation and the inputs.
module acumulador_nucleo
    import acumulador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             carry_in,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] acc_next,
    output logic             carry_next
);

    // Operation decode: each mode produces its result and the bit that leaves the register
    always_comb begin
        acc_next   = acc;
        carry_next = carry_in;
        case (mode)
            MODE_HOLD: begin
                acc_next   = acc;
                carry_next = carry_in;
            end
            MODE_LOAD: begin
                acc_next   = bus_in;
                carry_next = 1'b0;
            end
            MODE_SHL: begin
                acc_next   = {acc[WIDTH-2:0], serial_in};
                carry_next = acc[WIDTH-1];
            end
            MODE_SHR: begin
                acc_next   = {serial_in, acc[WIDTH-1:1]};
                carry_next = acc[0];
            end
            MODE_ROL: begin
                acc_next   = {acc[WIDTH-2:0], acc[WIDTH-1]};
                carry_next = acc[WIDTH-1];
            end
            MODE_ROR: begin
                acc_next   = {acc[0], acc[WIDTH-1:1]};
                carry_next = acc[0];
            end
            MODE_INC: begin
                acc_next   = acc + {{(WIDTH-1){1'b0}}, 1'b1};
                carry_next = &acc;
            end
            MODE_DEC: begin
                acc_next   = acc - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_next = ~|acc;
            end
            default: begin
                acc_next   = acc;
                carry_next = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/acumulador_param.sv
// Parameterised accumulator: register, Z/N/C flags and bus output gating.
// Build macro ACC_TRISTATE_EN: when defined, bus_out floats while ACC_OUT is
// low (shared bus); otherwise it drives zero (OR-combined bus).
module acumulador_param
    import acumulador_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             ACC_IN,
    input  logic [2:0]       ACC_MODE,
    input  logic             ACC_OUT,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] TO_ULA,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry_next;

    acumulador_nucleo #(
        .WIDTH (WIDTH)
    ) u_nucleo (
        .acc        (acc),
        .carry_in   (flag_c),
        .mode       (ACC_MODE),
        .serial_in  (serial_in),
        .bus_in     (bus_in),
        .acc_next   (acc_next),
        .carry_next (carry_next)
    );

    // Accumulator and flags: async clear to RESET_VAL, update only when enabled;
    // Z and N follow the new value on every enabled edge, HOLD included
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc    <= RESET_VAL;
            flag_c <= 1'b0;
            flag_z <= (RESET_VAL == '0);
            flag_n <= RESET_VAL[WIDTH-1];
        end else if (ACC_IN) begin
            acc    <= acc_next;
            flag_c <= carry_next;
            flag_z <= (acc_next == '0);
            flag_n <= acc_next[WIDTH-1];
        end
    end

    // ALU side sees the register directly, never the bus
    always_comb begin
        TO_ULA = acc;
    end

    // Bus drive: register value only, so a LOAD while driving cannot loop back
`ifdef ACC_TRISTATE_EN
    always_comb begin
        bus_out = ACC_OUT ? acc : {WIDTH{1'bz}};
    end
`else
    always_comb begin
        bus_out = ACC_OUT ? acc : '0;
    end
`endif

endmodule

// File: tb/tb_acumulador_param.sv
// Directed self-checking bench for acumulador_param (8-bit with RESET_VAL=80h,
// and a 16-bit instance with RESET_VAL=0).
module tb_acumulador_param;
    import acumulador_pkg::*;

    logic        clock;
    logic        clear;
    logic        acc_in8, acc_out8, si8;
    logic [2:0]  mode8;
    logic [7:0]  bus_in8, bus_out8, to_ula8;
    logic        z8, n8, c8;

    logic        acc_in16, acc_out16, si16;
    logic [2:0]  mode16;
    logic [15:0] bus_in16, bus_out16, to_ula16;
    logic        z16, n16, c16;

    int checks = 0;
    int errors = 0;

    acumulador_param #(
        .WIDTH     (8),
        .RESET_VAL (8'h80)
    ) u_dut8 (
        .clock     (clock),
        .clear     (clear),
        .ACC_IN    (acc_in8),
        .ACC_MODE  (mode8),
        .ACC_OUT   (acc_out8),
        .serial_in (si8),
        .bus_in    (bus_in8),
        .bus_out   (bus_out8),
        .TO_ULA    (to_ula8),
        .flag_z    (z8),
        .flag_n    (n8),
        .flag_c    (c8)
    );

    acumulador_param #(
        .WIDTH     (16),
        .RESET_VAL (16'h0000)
    ) u_dut16 (
        .clock     (clock),
        .clear     (clear),
        .ACC_IN    (acc_in16),
        .ACC_MODE  (mode16),
        .ACC_OUT   (acc_out16),
        .serial_in (si16),
        .bus_in    (bus_in16),
        .bus_out   (bus_out16),
        .TO_ULA    (to_ula16),
        .flag_z    (z16),
        .flag_n    (n16),
        .flag_c    (c16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] a, input logic z, input logic n, input logic c);
        check({tag, ".acc"}, {24'd0, to_ula8}, {24'd0, a});
        check({tag, ".z"}, {31'd0, z8}, {31'd0, z});
        check({tag, ".n"}, {31'd0, n8}, {31'd0, n});
        check({tag, ".c"}, {31'd0, c8}, {31'd0, c});
    endtask

    task automatic chk16(input string tag, input logic [15:0] a, input logic z, input logic n, input logic c);
        check({tag, ".acc"}, {16'd0, to_ula16}, {16'd0, a});
        check({tag, ".z"}, {31'd0, z16}, {31'd0, z});
        check({tag, ".n"}, {31'd0, n16}, {31'd0, n});
        check({tag, ".c"}, {31'd0, c16}, {31'd0, c});
    endtask

    // One enabled operation on the 8-bit instance; sampled 1 time unit after the edge
    task automatic op8(input logic [2:0] m, input logic si, input logic [7:0] b);
        @(negedge clock);
        acc_in8 = 1'b1; mode8 = m; si8 = si; bus_in8 = b;
        @(posedge clock);
        #1;
        acc_in8 = 1'b0;
    endtask

    task automatic op16(input logic [2:0] m, input logic si, input logic [15:0] b);
        @(negedge clock);
        acc_in16 = 1'b1; mode16 = m; si16 = si; bus_in16 = b;
        @(posedge clock);
        #1;
        acc_in16 = 1'b0;
    endtask

    initial begin
        clear = 1'b0;
        acc_in8 = 1'b0; mode8 = MODE_HOLD; acc_out8 = 1'b0; si8 = 1'b0; bus_in8 = '0;
        acc_in16 = 1'b0; mode16 = MODE_HOLD; acc_out16 = 1'b0; si16 = 1'b0; bus_in16 = '0;

        // Asynchronous clear before any clock edge
        #1 clear = 1'b1;
        #1;
        chk8("reset8", 8'h80, 1'b0, 1'b1, 1'b0);
        chk16("reset16", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;

        // LOAD FF, INC wraps, DEC borrows back
        op8(MODE_LOAD, 1'b0, 8'hFF);
        chk8("load_ff", 8'hFF, 1'b0, 1'b1, 1'b0);
        op8(MODE_INC, 1'b0, 8'h00);
        chk8("inc_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
        op8(MODE_DEC, 1'b0, 8'h00);
        chk8("dec_wrap", 8'hFF, 1'b0, 1'b1, 1'b1);
        op8(MODE_HOLD, 1'b1, 8'h55);
        chk8("hold", 8'hFF, 1'b0, 1'b1, 1'b1);

        // LOAD with bus driven: old value stays on bus until the edge
        @(negedge clock);
        acc_out8 = 1'b1; acc_in8 = 1'b1; mode8 = MODE_LOAD; bus_in8 = 8'h81;
        #1;
        check("bus_before_load", {24'd0, bus_out8}, 32'h0000_00FF);
        @(posedge clock);
        #1;
        acc_in8 = 1'b0;
        chk8("load_81", 8'h81, 1'b0, 1'b1, 1'b0);
        check("bus_after_load", {24'd0, bus_out8}, 32'h0000_0081);

        // Shift / rotate chain
        op8(MODE_SHL, 1'b0, 8'h00);
        chk8("shl", 8'h02, 1'b0, 1'b0, 1'b1);
        op8(MODE_ROR, 1'b1, 8'h00);
        chk8("ror", 8'h01, 1'b0, 1'b0, 1'b0);
        op8(MODE_SHR, 1'b1, 8'h00);
        chk8("shr", 8'h80, 1'b0, 1'b1, 1'b1);

        // Disabled for 5 cycles with INC selected: nothing moves
        @(negedge clock);
        acc_in8 = 1'b0; mode8 = MODE_INC; bus_in8 = 8'h11; acc_out8 = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk8("disabled", 8'h80, 1'b0, 1'b1, 1'b1);
`ifdef ACC_TRISTATE_EN
        check("bus_off", {24'd0, bus_out8}, {24'd0, 8'hzz});
`else
        check("bus_off", {24'd0, bus_out8}, 32'h0000_0000);
`endif

        // Rotate left across MSB, then DEC to zero without borrow
        op8(MODE_ROL, 1'b0, 8'h00);
        chk8("rol8", 8'h01, 1'b0, 1'b0, 1'b1);
        op8(MODE_DEC, 1'b0, 8'h00);
        chk8("dec_to_0", 8'h00, 1'b1, 1'b0, 1'b0);
        op8(MODE_INC, 1'b0, 8'h00);
        chk8("inc_no_c", 8'h01, 1'b0, 1'b0, 1'b0);

        // Clear mid-cycle during LOAD 3C: immediate, load lost
        @(negedge clock);
        acc_in8 = 1'b1; mode8 = MODE_LOAD; bus_in8 = 8'h3C;
        #2 clear = 1'b1;
        #1;
        chk8("clear_async", 8'h80, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        chk8("clear_over_load", 8'h80, 1'b0, 1'b1, 1'b0);

        // First enabled edge after clear executes normally
        @(negedge clock);
        clear = 1'b0; acc_in8 = 1'b1; mode8 = MODE_INC;
        @(posedge clock);
        #1;
        acc_in8 = 1'b0;
        chk8("first_after_clear", 8'h81, 1'b0, 1'b1, 1'b0);

        // 16-bit regression
        op16(MODE_LOAD, 1'b0, 16'hFFFF);
        chk16("load16", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        op16(MODE_INC, 1'b0, 16'h0000);
        chk16("inc16_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        op16(MODE_LOAD, 1'b0, 16'h8000);
        chk16("load16_8000", 16'h8000, 1'b0, 1'b1, 1'b0);
        op16(MODE_ROL, 1'b0, 16'h0000);
        chk16("rol16", 16'h0001, 1'b0, 1'b0, 1'b1);
        op16(MODE_ROR, 1'b0, 16'h0000);
        chk16("ror16", 16'h8000, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        acc_out16 = 1'b1;
        #1;
        check("bus16_on", {16'd0, bus_out16}, 32'h0000_8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
